multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback for the supported set: add, addi, sub, or, ori, and, andi, lui, nor, sll, srl, lw, sw, beq, bne, j, jal, jr.
- Produces the 3-bit ALUOp consumed by the ALU control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory ready handshake.

Parameters:
- MEM_WAIT_MAX, 15: cycles allowed waiting for mem_ready before mem_timeout is raised. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond_eq  out  1  load PC if ALU zero
- pc_write_cond_ne  out  1  load PC if not ALU zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  2  write register: 00=rt, 01=rd, 10=r31
- mem_to_reg  out  2  write data: 00=ALUOut, 01=MDR, 10=PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
- ext_zero  out  1  immediate extension: 1=zero-extend, 0=sign-extend
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump addr, 11=A (jr)
- ALUOp  out  3  000=add, 001=sub, 010=or, 011=and, 100=lui, 111=R-type (use funct)
- illegal_opcode  out  1  sticky; set on an unsupported opcode/funct
- mem_timeout  out  1  sticky; set when the mem_ready wait exceeds MEM_WAIT_MAX
- state_out  out  4  current state, for debug

Behaviour:
- Timing and reset
  - One clock: clk. Reset is synchronous and active-high.
  - On reset: state<=FETCH, wait counter<=0, illegal_opcode<=0, mem_timeout<=0.
  - While reset is high, all write/request enables (pc_write*, mem_read, mem_write, ir_write, reg_write) are forced 0.
  - Reset mid-instruction abandons the instruction. No partial write occurs in or after the reset cycle.
- Outputs
  - Moore outputs decoded from the state register only (plus opcode where noted). Unlisted enables are 0; unlisted selects are 00.
  - ext_zero=1 only in I_EXEC for ori/andi.
- States and transitions (encoding 0..14):
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=000. ir_write=pc_write=mem_ready. Stay while !mem_ready; ->DECODE on mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
    - 0x23/0x2B -> MEM_ADDR
    - 0x00 with funct 0x08 -> JR
    - 0x00 with funct in {20,22,24,25,27,00,02} -> R_EXEC
    - 0x08/0x0C/0x0D/0x0F -> I_EXEC
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - anything else -> ILLEGAL
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUOp=000. lw->MEM_READ, sw->MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Wait for mem_ready, then ->MEM_WB.
  - MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1. ->FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Wait for mem_ready, then ->FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00, ALUOp=111. ->R_WB.
  - R_WB: reg_dst=01, reg_write=1. ->FETCH.
  - I_EXEC: alu_src_a=1, alu_src_b=10. ALUOp: addi 000, ori 010, andi 011, lui 100. ->I_WB.
  - I_WB: reg_dst=00, mem_to_reg=00, reg_write=1. ->FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=001, pc_source=01. beq: pc_write_cond_eq=1; bne: pc_write_cond_ne=1. ->FETCH.
  - JUMP: pc_source=10, pc_write=1. ->FETCH.
  - JAL: pc_source=10, pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1 (r31 gets PC+4; no delay slot). ->FETCH.
  - JR: pc_source=11, pc_write=1. ->FETCH.
  - ILLEGAL: illegal_opcode=1. All enables 0. Absorbing until reset.
- CPI: R/I-type 4, lw 5, sw 4, branch/jump/jal/jr 3, each with zero wait states.
- Wait handling
  - The wait counter increments in FETCH/MEM_READ/MEM_WRITE while !mem_ready, and clears on any state change.
  - When the count reaches MEM_WAIT_MAX, mem_timeout is set and the FSM keeps waiting; it is not aborted.
  - mem_ready outside the wait states is ignored.

Decomposition:
- Shared package (mips_ctrl_pkg): state encodings, opcode/funct constants, ALUOp codes, reg_dst/mem_to_reg/alu_src_b/pc_source encodings.
- The ALU control decoder uses the same ALUOp constants.
- One sub-module: main_ctrl_outputs, a combinational state+opcode -> control word decoder.
- The FSM, wait counter and sticky flags stay in the top module.

Test Plan:
- add (opcode 0, funct 0x20), mem_ready=1 always -> states 0,1,6,7,0. ALUOp=111 in R_EXEC. reg_write=1 with reg_dst=01 only in R_WB.
- lw (0x23), mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=01. Total 8 cycles. mem_timeout=0.
- beq then bne -> BRANCH with ALUOp=001, pc_source=01. Only pc_write_cond_eq set for beq, only pc_write_cond_ne for bne.
- jal (0x03) -> JAL asserts pc_write, reg_write, reg_dst=10, mem_to_reg=10 in the same cycle. jr (0,0x08) -> pc_source=11.
- Opcode 0x3F -> ILLEGAL, illegal_opcode=1 and held with no enables for 20 cycles. reset -> FETCH, flag cleared.
- reset asserted in MEM_WRITE with mem_ready=0 -> mem_write=0 that cycle, FETCH next. Separately, mem_ready held low 16 cycles in FETCH -> mem_timeout=1 once the count reaches 15.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path: FSM state
// encodings, opcode/funct values, ALUOp codes (shared with the ALU control
// decoder), datapath mux encodings and the control-word structure produced by
// main_ctrl_outputs.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // FSM state encodings (state_out exposes these directly)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_I_EXEC    = 4'd8;
    localparam logic [3:0] S_I_WB      = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;
    localparam logic [3:0] S_JR        = 4'd13;
    localparam logic [3:0] S_ILLEGAL   = 4'd14;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALUOp codes, also decoded by the ALU control block
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_LUI   = 3'b100;
    localparam logic [2:0] ALUOP_RTYPE = 3'b111;

    // Datapath mux encodings
    localparam logic [1:0] REGDST_RT     = 2'b00;
    localparam logic [1:0] REGDST_RD     = 2'b01;
    localparam logic [1:0] REGDST_RA     = 2'b10;
    localparam logic [1:0] M2R_ALUOUT    = 2'b00;
    localparam logic [1:0] M2R_MDR       = 2'b01;
    localparam logic [1:0] M2R_PC        = 2'b10;
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_BR_OFS   = 2'b11;
    localparam logic [1:0] PCSRC_ALU     = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP    = 2'b10;
    localparam logic [1:0] PCSRC_REG     = 2'b11;

    // Complete control word for one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond_eq;
        logic       pc_write_cond_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_word_t;

    // All enables off, all selects 00
    localparam ctrl_word_t CTRL_NONE = ctrl_word_t'(21'd0);

    // R-type funct codes executed through R_EXEC (jr is routed separately)
    function automatic logic is_legal_rfunct(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: is_legal_rfunct = 1'b1;
            default:                                              is_legal_rfunct = 1'b0;
        endcase
    endfunction

    // ALU operation for the immediate-type instructions
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  imm_alu_op = ALUOP_OR;
            OP_ANDI: imm_alu_op = ALUOP_AND;
            OP_LUI:  imm_alu_op = ALUOP_LUI;
            default: imm_alu_op = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_outputs.sv
// -----------------------------------------------------------------------------
// main_ctrl_outputs
// Combinational decoder from FSM state (+ opcode, + mem_ready in FETCH) to the
// datapath control word. Reset gating of enables is done by the top level.
// Ports:
//   i_state     - current FSM state
//   i_opcode    - IR[31:26], selects I-type ALUOp and branch polarity
//   i_mem_ready - memory handshake; gates IR/PC load during fetch
//   o_ctrl      - control word
// -----------------------------------------------------------------------------
module main_ctrl_outputs
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]  i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    output ctrl_word_t  o_ctrl
);

    // State-to-control-word decode; anything not listed stays at CTRL_NONE
    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                // PC+4 and IR capture only when the fetch actually completes
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_BR_OFS;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_dst    = REGDST_RT;
                o_ctrl.mem_to_reg = M2R_MDR;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                o_ctrl.reg_dst   = REGDST_RD;
                o_ctrl.reg_write = 1'b1;
            end
            S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = imm_alu_op(i_opcode);
                // logical immediates are zero-extended, arithmetic ones sign-extended
                o_ctrl.ext_zero  = (i_opcode == OP_ORI) || (i_opcode == OP_ANDI);
            end
            S_I_WB: begin
                o_ctrl.reg_dst    = REGDST_RT;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
                o_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a        = 1'b1;
                o_ctrl.alu_src_b        = SRCB_B;
                o_ctrl.alu_op           = ALUOP_SUB;
                o_ctrl.pc_source        = PCSRC_ALUOUT;
                o_ctrl.pc_write_cond_eq = (i_opcode == OP_BEQ);
                o_ctrl.pc_write_cond_ne = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.pc_write  = 1'b1;
            end
            S_JAL: begin
                // link and jump in one cycle; PC still holds PC+4 here
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.reg_dst    = REGDST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.reg_write  = 1'b1;
            end
            S_JR: begin
                o_ctrl.pc_source = PCSRC_REG;
                o_ctrl.pc_write  = 1'b1;
            end
            S_ILLEGAL: o_ctrl = CTRL_NONE;
            default:   o_ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
// Main control FSM of the multicycle MIPS datapath: fetch, decode, execute,
// memory and writeback sequencing, memory-ready stalls with a timeout monitor,
// and a sticky illegal-instruction flag.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   opcode, funct     - IR[31:26], IR[5:0]
//   mem_ready         - memory completes current access this cycle
//   pc_write..ALUOp   - datapath control (see mips_ctrl_pkg encodings)
//   illegal_opcode    - sticky, unsupported instruction seen
//   mem_timeout       - sticky, a memory wait reached MEM_WAIT_MAX cycles
//   state_out         - current FSM state for debug
// -----------------------------------------------------------------------------
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond_eq,
    output logic       pc_write_cond_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_source,
    output logic [2:0] ALUOp,
    output logic       illegal_opcode,
    output logic       mem_timeout,
    output logic [3:0] state_out
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_inc;
    logic       w_waiting;
    logic       r_illegal;
    logic       r_timeout;
    ctrl_word_t w_ctrl;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:     w_state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEM_ADDR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            w_state_next = S_JR;
                        end else if (is_legal_rfunct(funct)) begin
                            w_state_next = S_R_EXEC;
                        end else begin
                            w_state_next = S_ILLEGAL;
                        end
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_state_next = S_I_EXEC;
                    OP_BEQ, OP_BNE:                   w_state_next = S_BRANCH;
                    OP_J:                             w_state_next = S_JUMP;
                    OP_JAL:                           w_state_next = S_JAL;
                    default:                          w_state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  w_state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_state_next = S_FETCH;
            S_MEM_WRITE: w_state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_state_next = S_R_WB;
            S_R_WB:      w_state_next = S_FETCH;
            S_I_EXEC:    w_state_next = S_I_WB;
            S_I_WB:      w_state_next = S_FETCH;
            S_BRANCH:    w_state_next = S_FETCH;
            S_JUMP:      w_state_next = S_FETCH;
            S_JAL:       w_state_next = S_FETCH;
            S_JR:        w_state_next = S_FETCH;
            S_ILLEGAL:   w_state_next = S_ILLEGAL;
            // unused encoding 15 recovers to fetch
            default:     w_state_next = S_FETCH;
        endcase
    end

    // Stall detection and saturating wait-count increment
    always_comb begin
        w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                      (r_state == S_MEM_WRITE)) && !mem_ready;
        w_wait_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : (r_wait_cnt + 8'd1);
    end

    // State register, wait counter and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_waiting) begin
                r_wait_cnt <= w_wait_inc;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            // timeout only flags the condition; the FSM keeps waiting
            if (w_waiting && (w_wait_inc >= WAIT_LIMIT)) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
            if (w_state_next == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end else begin
                r_illegal <= r_illegal;
            end
        end
    end

    main_ctrl_outputs u_outputs (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Enables are suppressed during reset so an abandoned instruction cannot write
    assign pc_write         = w_ctrl.pc_write         & ~reset;
    assign pc_write_cond_eq = w_ctrl.pc_write_cond_eq & ~reset;
    assign pc_write_cond_ne = w_ctrl.pc_write_cond_ne & ~reset;
    assign mem_read         = w_ctrl.mem_read         & ~reset;
    assign mem_write        = w_ctrl.mem_write        & ~reset;
    assign ir_write         = w_ctrl.ir_write         & ~reset;
    assign reg_write        = w_ctrl.reg_write        & ~reset;
    assign i_or_d           = w_ctrl.i_or_d;
    assign reg_dst          = w_ctrl.reg_dst;
    assign mem_to_reg       = w_ctrl.mem_to_reg;
    assign alu_src_a        = w_ctrl.alu_src_a;
    assign alu_src_b        = w_ctrl.alu_src_b;
    assign ext_zero         = w_ctrl.ext_zero;
    assign pc_source        = w_ctrl.pc_source;
    assign ALUOp            = w_ctrl.alu_op;
    assign illegal_opcode   = r_illegal;
    assign mem_timeout      = r_timeout;
    assign state_out        = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
// Self-checking bench: inputs change 1 time unit after the rising edge, outputs
// are sampled on the falling edge. Expected behaviour comes from an
// instruction-level reference: each instruction expands to its list of
// architectural steps, each step has its tabulated control word.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write, pc_write_cond_eq, pc_write_cond_ne, i_or_d;
    logic       mem_read, mem_write, ir_write, reg_write, alu_src_a, ext_zero;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] ALUOp;
    logic       illegal_opcode, mem_timeout;
    logic [3:0] state_out;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_path[$];
    logic exp_to;

    multicycle_main_control #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq),
        .pc_write_cond_ne(pc_write_cond_ne), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_source(pc_source),
        .ALUOp(ALUOp), .illegal_opcode(illegal_opcode), .mem_timeout(mem_timeout),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    wire [20:0] obs_ctrl = {pc_write, pc_write_cond_eq, pc_write_cond_ne, i_or_d,
                            mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                            reg_write, alu_src_a, alu_src_b, ext_zero, pc_source, ALUOp};
    wire [6:0]  obs_en   = {pc_write, pc_write_cond_eq, pc_write_cond_ne, mem_read,
                            mem_write, ir_write, reg_write};

    // Step numbers as seen on state_out
    localparam int FETCH = 0, DECODE = 1, MADDR = 2, MREAD = 3, MWB = 4, MWRITE = 5;
    localparam int REXE = 6, RWB = 7, IEXE = 8, IWB = 9, BR = 10, JMP = 11, JAL = 12;
    localparam int JR = 13, ILL = 14;

    // Supported instruction table; funct only matters for opcode 0
    logic [5:0] op_tab [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08,
                                6'h0D, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                6'h03, 6'h00};
    logic [5:0] fn_tab [18] = '{6'h20, 6'h22, 6'h25, 6'h24, 6'h27, 6'h00, 6'h02, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h08};

    // Control word the spec tables give for one step of an instruction
    function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] op, input logic mr);
        logic pcw, ceq, cne, iod, mrd, mwr, irw, rw, asa, ez;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] aop;
        {pcw, ceq, cne, iod, mrd, mwr, irw, rw, asa, ez} = 10'd0;
        {rd, m2r, asb, pcs} = 8'd0;
        aop = 3'd0;
        case (st)
            FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            DECODE: asb = 2'b11;
            MADDR:  begin asa = 1'b1; asb = 2'b10; end
            MREAD:  begin mrd = 1'b1; iod = 1'b1; end
            MWB:    begin m2r = 2'b01; rw = 1'b1; end
            MWRITE: begin mwr = 1'b1; iod = 1'b1; end
            REXE:   begin asa = 1'b1; aop = 3'b111; end
            RWB:    begin rd = 2'b01; rw = 1'b1; end
            IEXE: begin
                asa = 1'b1; asb = 2'b10;
                ez  = (op == 6'h0C) || (op == 6'h0D);
                aop = (op == 6'h0D) ? 3'b010 : (op == 6'h0C) ? 3'b011 :
                      (op == 6'h0F) ? 3'b100 : 3'b000;
            end
            IWB:    rw = 1'b1;
            BR:     begin asa = 1'b1; aop = 3'b001; pcs = 2'b01;
                          ceq = (op == 6'h04); cne = (op == 6'h05); end
            JMP:    begin pcs = 2'b10; pcw = 1'b1; end
            JAL:    begin pcs = 2'b10; pcw = 1'b1; rd = 2'b10; m2r = 2'b10; rw = 1'b1; end
            JR:     begin pcs = 2'b11; pcw = 1'b1; end
            default: ;
        endcase
        return {pcw, ceq, cne, iod, mrd, mwr, irw, rd, m2r, rw, asa, asb, ez, pcs, aop};
    endfunction

    // Sequence of steps an instruction walks through
    task automatic make_path(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:        exp_path = (fn == 6'h08) ? '{FETCH, DECODE, JR} : '{FETCH, DECODE, REXE, RWB};
            6'h08, 6'h0C, 6'h0D, 6'h0F: exp_path = '{FETCH, DECODE, IEXE, IWB};
            6'h23:        exp_path = '{FETCH, DECODE, MADDR, MREAD, MWB};
            6'h2B:        exp_path = '{FETCH, DECODE, MADDR, MWRITE};
            6'h04, 6'h05: exp_path = '{FETCH, DECODE, BR};
            6'h02:        exp_path = '{FETCH, DECODE, JMP};
            6'h03:        exp_path = '{FETCH, DECODE, JAL};
            default:      exp_path = '{FETCH, DECODE, ILL};
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h00;
        tick(); tick();
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0 || illegal_opcode !== 1'b0 || mem_timeout !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: state=%0d ill=%b to=%b, want 0 0 0", state_out, illegal_opcode, mem_timeout);
        end
        n_vec++;
        if (obs_en !== 7'd0) begin
            n_miss++;
            $display("FAIL reset_enables: got %b, want 0000000", obs_en);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_release: state=%0d ir_write=%b pc_write=%b, want 0 1 1", state_out, ir_write, pc_write);
        end
        tick();
    endtask

    // Directed pass over every supported instruction, then random instructions
    task automatic test_sequence(input int n_rand, input int stall_pct);
        logic [5:0] op, fn;
        logic mr;
        int idx, run, cyc;
        bit waitst;
        do_reset();
        for (int k = 0; k < 18 + n_rand; k++) begin
            idx = (k < 18) ? k : int'($urandom_range(0, 17));
            op  = op_tab[idx];
            fn  = (op == 6'h00) ? fn_tab[idx] : 6'($urandom);
            make_path(op, fn);
            foreach (exp_path[j]) begin
                run = 0;
                cyc = 0;
                waitst = (exp_path[j] == FETCH) || (exp_path[j] == MREAD) || (exp_path[j] == MWRITE);
                do begin
                    if (waitst)
                        mr = (run < 6 && int'($urandom_range(0, 99)) < stall_pct) ? 1'b0 : 1'b1;
                    else
                        mr = 1'($urandom);
                    mem_ready = mr; opcode = op; funct = fn;
                    @(negedge clk);
                    n_vec++;
                    if (state_out !== 4'(exp_path[j])) begin
                        n_miss++;
                        $display("FAIL seq_state op=%h fn=%h: state=%0d, want %0d", op, fn, state_out, exp_path[j]);
                    end
                    n_vec++;
                    if ({obs_ctrl, illegal_opcode, mem_timeout} !== {exp_ctrl(exp_path[j], op, mr), 1'b0, exp_to}) begin
                        n_miss++;
                        $display("FAIL seq_ctrl op=%h step=%0d: got %h/%b%b, want %h/0%b", op, exp_path[j],
                                 obs_ctrl, illegal_opcode, mem_timeout, exp_ctrl(exp_path[j], op, mr), exp_to);
                    end
                    if (waitst && !mr) begin
                        run++;
                        if (run >= 15) exp_to = 1'b1;
                    end
                    tick();
                    cyc++;
                end while (waitst && !mr && cyc < 40);
            end
        end
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0) begin
            n_miss++;
            $display("FAIL seq_end: state=%0d, want 0", state_out);
        end
    endtask

    task automatic test_lw_stall();
        int cycles;
        do_reset();
        opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
        cycles = 3;
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            n_vec++;
            if (state_out !== 4'd3 || mem_read !== 1'b1 || i_or_d !== 1'b1) begin
                n_miss++;
                $display("FAIL lw_wait%0d: state=%0d rd=%b iod=%b, want 3 1 1", i, state_out, mem_read, i_or_d);
            end
            tick();
            cycles++;
        end
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd4 || mem_to_reg !== 2'b01 || reg_write !== 1'b1 || mem_timeout !== 1'b0) begin
            n_miss++;
            $display("FAIL lw_wb: state=%0d m2r=%b rw=%b to=%b, want 4 01 1 0", state_out, mem_to_reg, reg_write, mem_timeout);
        end
        tick();
        cycles++;
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0 || cycles !== 8) begin
            n_miss++;
            $display("FAIL lw_total: state=%0d cycles=%0d, want 0 8", state_out, cycles);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'h3F; funct = 6'h20; mem_ready = 1'b1;
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (state_out !== 4'd14 || illegal_opcode !== 1'b1 || obs_ctrl !== 21'd0) begin
                n_miss++;
                $display("FAIL illegal_hold%0d: state=%0d ill=%b ctrl=%h, want 14 1 0", i, state_out, illegal_opcode, obs_ctrl);
            end
            tick();
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0 || illegal_opcode !== 1'b0) begin
            n_miss++;
            $display("FAIL illegal_clear: state=%0d ill=%b, want 0 0", state_out, illegal_opcode);
        end
        // unsupported R-type funct
        opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd14 || illegal_opcode !== 1'b1) begin
            n_miss++;
            $display("FAIL illegal_funct: state=%0d ill=%b, want 14 1", state_out, illegal_opcode);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd5 || mem_write !== 1'b1) begin
            n_miss++;
            $display("FAIL sw_write: state=%0d wr=%b, want 5 1", state_out, mem_write);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_write !== 1'b0 || obs_en !== 7'd0) begin
            n_miss++;
            $display("FAIL sw_reset_gate: wr=%b en=%b, want 0 0000000", mem_write, obs_en);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd0) begin
            n_miss++;
            $display("FAIL sw_reset_fetch: state=%0d, want 0", state_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            n_vec++;
            if (state_out !== 4'd0 || mem_timeout !== (k >= 15)) begin
                n_miss++;
                $display("FAIL timeout_k%0d: state=%0d to=%b, want 0 %b", k, state_out, mem_timeout, (k >= 15));
            end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if (state_out !== 4'd1 || mem_timeout !== 1'b1) begin
            n_miss++;
            $display("FAIL timeout_sticky: state=%0d to=%b, want 1 1", state_out, mem_timeout);
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if (mem_timeout !== 1'b0) begin
            n_miss++;
            $display("FAIL timeout_clear: to=%b, want 0", mem_timeout);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00; exp_to = 1'b0;
        test_reset();
        test_sequence(0, 0);
        test_sequence(80, 30);
        test_lw_stall();
        test_illegal();
        test_reset_mid_write();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
